// File: rtl/axi4_lite_slave_pkg.sv
// Shared types and address-decode helpers for the AXI4-Lite register slave.
package axi4_lite_slave_pkg;

  typedef enum logic [0:0] {
    R_IDLE  = 1'b0,
    R_VALID = 1'b1
  } rd_state_e;

  // Byte-offset bits within one data word.
  function automatic int unsigned ofs_f(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  // Register-index bits.
  function automatic int unsigned iw_f(input int unsigned num_regs);
    return $clog2(num_regs);
  endfunction

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_NUM_REGS   = 16;
  localparam int unsigned OFS            = ofs_f(DEF_DATA_WIDTH);
  localparam int unsigned IW             = iw_f(DEF_NUM_REGS);

endpackage

// File: rtl/axi4_lite_hold1.sv
// One-entry holding register: captures data_i on load_i, empties on clear_i.
module axi4_lite_hold1 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave with a bank of word-wide registers; AW and W buffered one
// deep each, reads answered one cycle after the AR handshake.
module axi4_lite_slave_regs
  import axi4_lite_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int unsigned OFS_L = ofs_f(DATA_WIDTH);
  localparam int unsigned IW_L  = iw_f(NUM_REGS);

  logic                  rst_done_q;
  logic                  aw_full, w_full;
  logic [ADDR_WIDTH-1:0] aw_held;
  logic [DATA_WIDTH-1:0] w_held;
  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [IW_L-1:0]       wr_idx, rd_idx;
  logic                  wr_in_range, rd_in_range;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  rd_state_e             rd_state_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) rst_done_q <= 1'b0;
    else          rst_done_q <= 1'b1;
  end

  assign AWREADY = rst_done_q & ~aw_full;
  assign WREADY  = rst_done_q & ~w_full;
  assign ARREADY = rst_done_q & (rd_state_q == R_IDLE);

  assign aw_hs  = AWVALID & AWREADY;
  assign w_hs   = WVALID & WREADY;
  assign ar_hs  = ARVALID & ARREADY;
  assign commit = (aw_full | aw_hs) & (w_full | w_hs);

  // A side is only parked when its partner is not available this cycle.
  axi4_lite_hold1 #(.WIDTH(ADDR_WIDTH)) u_aw_hold (
    .clk_i   (ACLK),
    .rst_ni  (ARESETn),
    .load_i  (aw_hs & ~commit),
    .clear_i (commit),
    .data_i  (AWADDR),
    .full_o  (aw_full),
    .data_o  (aw_held)
  );

  axi4_lite_hold1 #(.WIDTH(DATA_WIDTH)) u_w_hold (
    .clk_i   (ACLK),
    .rst_ni  (ARESETn),
    .load_i  (w_hs & ~commit),
    .clear_i (commit),
    .data_i  (WDATA),
    .full_o  (w_full),
    .data_o  (w_held)
  );

  assign wr_addr     = aw_full ? aw_held : AWADDR;
  assign wr_data     = w_full ? w_held : WDATA;
  assign wr_idx      = wr_addr[OFS_L +: IW_L];
  assign wr_in_range = (wr_addr >> (OFS_L + IW_L)) == '0;
  assign rd_idx      = ARADDR[OFS_L +: IW_L];
  assign rd_in_range = (ARADDR >> (OFS_L + IW_L)) == '0;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      regs_q <= '{default: '0};
    end else if (commit && wr_in_range) begin
      regs_q[wr_idx] <= wr_data;
    end
  end

  // Reads sample regs_q before this edge's write lands, so a same-index
  // collision returns the old value.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_state_q <= R_IDLE;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            rdata_q    <= rd_in_range ? regs_q[rd_idx] : '0;
            rvalid_q   <= 1'b1;
            rd_state_q <= R_VALID;
          end
        end
        R_VALID: begin
          if (RREADY) begin
            rvalid_q   <= 1'b0;
            rd_state_q <= R_IDLE;
          end
        end
        default: begin
          rvalid_q   <= 1'b0;
          rd_state_q <= R_IDLE;
        end
      endcase
    end
  end

  assign RVALID = rvalid_q;
  assign RDATA  = rdata_q;

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed bench for axi4_lite_slave_regs with a queue-based reference model.
module tb_axi4_lite_slave_regs;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 16;

  logic          ACLK    = 1'b0;
  logic          ARESETn = 1'b0;
  logic [AW-1:0] AWADDR  = '0;
  logic          AWVALID = 1'b0;
  logic          AWREADY;
  logic [DW-1:0] WDATA   = '0;
  logic          WVALID  = 1'b0;
  logic          WREADY;
  logic [AW-1:0] ARADDR  = '0;
  logic          ARVALID = 1'b0;
  logic          ARREADY;
  logic [DW-1:0] RDATA;
  logic          RVALID;
  logic          RREADY  = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  axi4_lite_slave_regs #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_REGS  (NR)
  ) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RVALID  (RVALID),
    .RREADY  (RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register file as an array, each write channel as a queue.
  logic [DW-1:0] m_mem [NR];
  logic [AW-1:0] m_awq [$];
  logic [DW-1:0] m_wq  [$];
  bit            m_done = 1'b0;
  bit            m_rv   = 1'b0;
  logic [DW-1:0] m_rd   = '0;
  bit            m_awr, m_wr, m_arr;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d;

  function automatic bit in_rng(input logic [AW-1:0] a);
    return a < AW'(NR * (DW / 8));
  endfunction

  function automatic int idx_of(input logic [AW-1:0] a);
    return int'((a / (DW / 8)) % NR);
  endfunction

  initial foreach (m_mem[i]) m_mem[i] = '0;

  initial forever begin
    @(posedge ACLK or negedge ARESETn);
    if (!ARESETn) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_awq.delete();
      m_wq.delete();
      m_done = 1'b0;
      m_rv   = 1'b0;
      m_rd   = '0;
    end else begin
      m_awr = m_done && (m_awq.size() == 0);
      m_wr  = m_done && (m_wq.size() == 0);
      m_arr = m_done && !m_rv;
      if (AWVALID && m_awr) m_awq.push_back(AWADDR);
      if (WVALID && m_wr)   m_wq.push_back(WDATA);
      if (m_rv && RREADY) begin
        m_rv = 1'b0;
      end else if (ARVALID && m_arr) begin
        m_rd = in_rng(ARADDR) ? m_mem[idx_of(ARADDR)] : '0;
        m_rv = 1'b1;
      end
      if (m_awq.size() > 0 && m_wq.size() > 0) begin
        m_a = m_awq.pop_front();
        m_d = m_wq.pop_front();
        if (in_rng(m_a)) m_mem[idx_of(m_a)] = m_d;
      end
      m_done = 1'b1;
    end
  end

  initial forever begin
    @(negedge ACLK);
    check("awready", AWREADY, m_done && (m_awq.size() == 0));
    check("wready",  WREADY,  m_done && (m_wq.size() == 0));
    check("arready", ARREADY, m_done && !m_rv);
    check("rvalid",  RVALID,  m_rv);
    check("rdata",   RDATA,   m_rd);
  end

  // All stimulus tasks are entered and left on a falling edge.
  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ad = 1'b0;
    bit wd = 1'b0;
    AWADDR = a; AWVALID = 1'b1;
    WDATA  = d; WVALID  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (AWREADY) ad = 1'b1;
      if (WREADY)  wd = 1'b1;
      @(negedge ACLK);
      if (ad) AWVALID = 1'b0;
      if (wd) WVALID  = 1'b0;
      if (ad && wd) break;
    end
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    check("write_handshake", {62'b0, ad, wd}, 64'd3);
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
    bit got = 1'b0;
    ARADDR = a; ARVALID = 1'b1; RREADY = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      got = ARREADY;
      @(negedge ACLK);
    end
    ARVALID = 1'b0;
    check("ar_handshake", got, 1);
    lat = 1;
    while (!RVALID && lat < 20) begin
      @(negedge ACLK);
      lat++;
    end
    d = RDATA;
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
  endtask

  logic [DW-1:0] rd;
  int            lat;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset release.
    repeat (3) @(negedge ACLK);
    check("rst_awready", AWREADY, 0);
    check("rst_rvalid",  RVALID,  0);
    ARESETn = 1'b1;
    check("release_wready",  WREADY,  0);
    check("release_arready", ARREADY, 0);
    @(negedge ACLK);
    check("ready_awready", AWREADY, 1);
    check("ready_wready",  WREADY,  1);
    check("ready_arready", ARREADY, 1);
    check("ready_rdata",   RDATA,   0);

    // Paired write, then read with one-cycle latency.
    axi_write(32'h08, 32'hDEADBEEF);
    axi_read(32'h08, rd, lat);
    check("paired_rdata", rd, 32'hDEADBEEF);
    check("paired_latency", lat, 1);

    // Split write: data first, address three cycles later.
    WDATA = 32'h1234; WVALID = 1'b1;
    check("split_wready_first", WREADY, 1);
    @(negedge ACLK);
    WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("split_wready_held", WREADY, 0);
      if (i == 2) begin
        AWADDR = 32'h04; AWVALID = 1'b1;
        check("split_awready", AWREADY, 1);
      end
      @(negedge ACLK);
    end
    AWVALID = 1'b0;
    check("split_wready_after", WREADY, 1);
    axi_read(32'h04, rd, lat);
    check("split_rdata", rd, 32'h1234);

    // R backpressure.
    axi_write(32'h00, 32'h55AA);
    ARADDR = 32'h00; ARVALID = 1'b1; RREADY = 1'b0;
    check("bp_arready", ARREADY, 1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_rvalid",  RVALID,  1);
      check("bp_rdata",   RDATA,   32'h55AA);
      check("bp_arready_low", ARREADY, 0);
      @(negedge ACLK);
    end
    RREADY = 1'b1;
    check("bp_rvalid_last", RVALID, 1);
    @(negedge ACLK);
    RREADY = 1'b0;
    check("bp_rvalid_done", RVALID, 0);
    check("bp_arready_back", ARREADY, 1);

    // Out-of-range address: consumed, no aliasing onto reg[0].
    axi_write(32'h40, 32'hFFFFFFFF);
    axi_read(32'h40, rd, lat);
    check("oor_rdata", rd, 0);
    axi_read(32'h00, rd, lat);
    check("oor_reg0_kept", rd, 32'h55AA);

    // Read/write collision on the same index returns the old value.
    axi_write(32'h08, 32'hA);
    AWADDR = 32'h08; WDATA = 32'hB; AWVALID = 1'b1; WVALID = 1'b1;
    ARADDR = 32'h08; ARVALID = 1'b1; RREADY = 1'b0;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    check("coll_rvalid", RVALID, 1);
    check("coll_rdata_old", RDATA, 32'hA);
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    axi_read(32'h08, rd, lat);
    check("coll_rdata_new", rd, 32'hB);

    // Back-to-back writes at one per cycle.
    for (int i = 0; i < 4; i++) begin
      AWADDR = 32'h10 + 32'(4 * i); WDATA = 32'h100 + 32'(i);
      AWVALID = 1'b1; WVALID = 1'b1;
      check("b2b_awready", AWREADY, 1);
      check("b2b_wready",  WREADY,  1);
      @(negedge ACLK);
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    axi_read(32'h14, rd, lat);
    check("b2b_rdata1", rd, 32'h101);
    axi_read(32'h1C, rd, lat);
    check("b2b_rdata3", rd, 32'h103);

    // Reset mid-operation: held W and pending R are discarded.
    WDATA = 32'h77; WVALID = 1'b1;
    @(negedge ACLK);
    WVALID = 1'b0;
    ARADDR = 32'h08; ARVALID = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0;
    check("mid_rvalid_before", RVALID, 1);
    #2 ARESETn = 1'b0;
    #1;
    check("mid_rvalid_async", RVALID, 0);
    check("mid_rdata_async",  RDATA,  0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    axi_write(32'h0C, 32'h99);
    axi_read(32'h0C, rd, lat);
    check("mid_fresh_pair", rd, 32'h99);
    axi_read(32'h08, rd, lat);
    check("mid_regs_cleared", rd, 0);

    repeat (2) @(negedge ACLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
